pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the write-enables, flushes and bubbles of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It covers three cases:
- load-use data hazards;
- taken-branch squashes;
- multi-cycle data-memory accesses, through a req/ready handshake with timeout.

It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before entering ERR (must be >= 2)
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
rs1_IF_ID  in  5  rs1 of instruction in ID
rs2_IF_ID  in  5  rs2 of instruction in ID
uses_rs1_IF_ID  in  1  ID instruction reads rs1
uses_rs2_IF_ID  in  1  ID instruction reads rs2
rd_ID_EX  in  5  destination of instruction in EX
mem_read_ID_EX  in  1  EX instruction is a load
branch_taken_EX  in  1  EX resolved a taken branch/jump
mem_access_EX_MEM  in  1  MEM-stage instruction is a load/store
dmem_ready  in  1  data memory completes access this cycle
dmem_req  out  1  data memory request
pc_en  out  1  PC write enable
if_id_en  out  1  IF/ID write enable
if_id_flush  out  1  IF/ID load NOP
id_ex_en  out  1  ID/EX write enable
id_ex_flush  out  1  ID/EX load bubble (control zeroed)
ex_mem_en  out  1  EX/MEM write enable
mem_wb_bubble  out  1  MEM/WB load bubble
mem_err  out  1  sticky memory timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Reset: state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0. While reset=1, all enables, flushes, bubbles and dmem_req are 0.
- The control outputs are combinational from state and inputs, so they take effect in the same cycle. State, wait_cnt, mem_err and stall_cycles are registered.
- load_use = mem_read_ID_EX & (rd_ID_EX!=0) & ((uses_rs1_IF_ID & rs1_IF_ID==rd_ID_EX) | (uses_rs2_IF_ID & rs2_IF_ID==rd_ID_EX)).
- mem_busy = mem_access_EX_MEM & ~dmem_ready.
- dmem_req = mem_access_EX_MEM in RUN and MEM_WAIT; 0 in ERR.
- RUN uses this priority order:
  1. mem_busy: freeze all. pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_bubble=1. Next state MEM_WAIT, wait_cnt<=1.
  2. branch_taken_EX: all enables=1, if_id_flush=1, id_ex_flush=1. load_use is ignored because the ID instruction is squashed.
  3. load_use: pc_en=if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=1. This inserts a single bubble; the stall lasts one cycle because the load advances to MEM.
  4. otherwise: all enables=1, no flush or bubble.
- MEM_WAIT:
  - dmem_ready=0: freeze exactly as in case 1 and increment wait_cnt. If wait_cnt==MEM_TIMEOUT-1, go to ERR and set mem_err<=1.
  - dmem_ready=1: evaluate priorities 2-4 exactly as in RUN, go to RUN, wait_cnt<=0. A branch that was held during the freeze is applied on this cycle.
- ERR: all enables=0, mem_wb_bubble=1, dmem_req=0. Stays in ERR until reset; mem_err stays 1.
- stall_cycles increments on each non-reset cycle with pc_en=0 and state!=ERR. It saturates at all-ones.
- Simultaneous events:
  - mem_busy outranks branch and load_use.
  - branch outranks load_use.
  - A reset asserted during MEM_WAIT returns to RUN next cycle and drops dmem_req immediately.

Decomposition:
- Shared package pipe_ctrl_pkg holds the state enum (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2) and the register-index width constant (5).
- One natural sub-module, hazard_detect: the combinational load_use comparator, reusable by the forwarding unit.

Test Plan:
1. Load-use: EX has a load with rd=5 and ID uses rs1=5 -> exactly 1 cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles 0->1. Same test with rd=0 -> no stall.
2. Branch: branch_taken_EX=1 with load_use also true -> if_id_flush=1, id_ex_flush=1, pc_en=1, stall_cycles unchanged.
3. Memory wait: mem_access_EX_MEM=1, dmem_ready low for 3 cycles then high -> freeze for 3 cycles (mem_wb_bubble=1), dmem_req=1 for 4 cycles, RUN on 5th, stall_cycles=3.
4. Timeout: MEM_TIMEOUT=16, dmem_ready held 0 -> mem_err=1 after 16 freeze cycles, state ERR, dmem_req=0, and mem_err still set 10 cycles later.
5. Branch held during freeze: branch_taken_EX=1 while in MEM_WAIT -> no flush until the dmem_ready cycle, then if_id_flush=id_ex_flush=1 in that cycle.
6. Reset mid-wait: reset=1 during MEM_WAIT -> same cycle all outputs 0; next cycle RUN, mem_err=0, stall_cycles=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  // Register-file index width (x0..x31)
  localparam int REG_IDX_W = 5;

  // Sequencer states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  // Per-cycle pipeline-register control bundle
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_bubble;
  } ctrl_t;

  // Everything idle: used while reset is held
  localparam ctrl_t CTRL_IDLE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
    id_ex_en: 1'b0, id_ex_flush: 1'b0, ex_mem_en: 1'b0,
    mem_wb_bubble: 1'b0
  };

  // Whole pipe frozen, MEM/WB receives a bubble
  localparam ctrl_t CTRL_FREEZE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
    id_ex_en: 1'b0, id_ex_flush: 1'b0, ex_mem_en: 1'b0,
    mem_wb_bubble: 1'b1
  };

  // Control when memory is not holding the pipe: branch squash beats
  // load-use because the ID instruction is discarded anyway.
  function automatic ctrl_t flow_ctrl(input logic branch_taken,
                                      input logic load_use);
    ctrl_t c;
    c = '{
      pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
      id_ex_en: 1'b1, id_ex_flush: 1'b0, ex_mem_en: 1'b1,
      mem_wb_bubble: 1'b0
    };
    if (branch_taken) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (load_use) begin
      c.pc_en       = 1'b0;
      c.if_id_en    = 1'b0;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard inputs, pipeline-register controls and data-memory
// handshake between the pipeline and the hazard sequencer.
//
// Data-memory handshake: dmem_req is high while the MEM-stage instruction
// is a load/store and the sequencer is not in ERR. The access completes in
// the cycle where dmem_req and dmem_ready are both high; while dmem_req is
// high and dmem_ready is low the pipe is frozen and the request is held.
interface pipe_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic [REG_IDX_W-1:0] rs1_IF_ID;
  logic [REG_IDX_W-1:0] rs2_IF_ID;
  logic                 uses_rs1_IF_ID;
  logic                 uses_rs2_IF_ID;
  logic [REG_IDX_W-1:0] rd_ID_EX;
  logic                 mem_read_ID_EX;
  logic                 branch_taken_EX;
  logic                 mem_access_EX_MEM;
  logic                 dmem_ready;
  logic                 dmem_req;
  logic                 pc_en;
  logic                 if_id_en;
  logic                 if_id_flush;
  logic                 id_ex_en;
  logic                 id_ex_flush;
  logic                 ex_mem_en;
  logic                 mem_wb_bubble;
  logic                 mem_err;
  logic [CNT_W-1:0]     stall_cycles;
  state_t               state_dbg;

  // Pipeline side: supplies hazard info, consumes controls
  modport master (
    output rs1_IF_ID, rs2_IF_ID, uses_rs1_IF_ID, uses_rs2_IF_ID,
    output rd_ID_EX, mem_read_ID_EX, branch_taken_EX,
    output mem_access_EX_MEM, dmem_ready,
    input  dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en,
    input  id_ex_flush, ex_mem_en, mem_wb_bubble, mem_err,
    input  stall_cycles, state_dbg
  );

  // Sequencer side
  modport slave (
    input  rs1_IF_ID, rs2_IF_ID, uses_rs1_IF_ID, uses_rs2_IF_ID,
    input  rd_ID_EX, mem_read_ID_EX, branch_taken_EX,
    input  mem_access_EX_MEM, dmem_ready,
    output dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en,
    output id_ex_flush, ex_mem_en, mem_wb_bubble, mem_err,
    output stall_cycles, state_dbg
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: the ID instruction reads a register that the load
// now in EX has not yet produced. x0 never creates a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] i_rs1,
  input  logic [REG_IDX_W-1:0] i_rs2,
  input  logic                 i_uses_rs1,
  input  logic                 i_uses_rs2,
  input  logic [REG_IDX_W-1:0] i_rd,
  input  logic                 i_mem_read,
  output logic                 o_load_use
);
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_uses_rs1 && (i_rs1 == i_rd);
  assign w_rs2_hit  = i_uses_rs2 && (i_rs2 == i_rd);
  assign o_load_use = i_mem_read && (i_rd != '0) && (w_rs1_hit || w_rs2_hit);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// taken-branch squashes, and data-memory wait with timeout to ERR.
// Controls are combinational from state and inputs; state, wait counter,
// error flag and stall counter are registered. MEM_TIMEOUT must be >= 2.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
)(
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic  w_load_use;
  logic  w_mem_busy;
  logic  w_dmem_req;
  ctrl_t w_ctrl;

  hazard_detect u_hazard_detect (
    .i_rs1      (bus.rs1_IF_ID),
    .i_rs2      (bus.rs2_IF_ID),
    .i_uses_rs1 (bus.uses_rs1_IF_ID),
    .i_uses_rs2 (bus.uses_rs2_IF_ID),
    .i_rd       (bus.rd_ID_EX),
    .i_mem_read (bus.mem_read_ID_EX),
    .o_load_use (w_load_use)
  );

  assign w_mem_busy = bus.mem_access_EX_MEM && !bus.dmem_ready;

  // Per-cycle controls; reset forces everything low immediately
  always_comb begin
    w_ctrl     = CTRL_IDLE;
    w_dmem_req = 1'b0;
    if (!reset) begin
      case (r_state)
        RUN: begin
          w_dmem_req = bus.mem_access_EX_MEM;
          w_ctrl     = w_mem_busy ? CTRL_FREEZE
                                  : flow_ctrl(bus.branch_taken_EX, w_load_use);
        end
        MEM_WAIT: begin
          // A branch held during the freeze is applied on the ready cycle
          w_dmem_req = bus.mem_access_EX_MEM;
          w_ctrl     = bus.dmem_ready ? flow_ctrl(bus.branch_taken_EX, w_load_use)
                                      : CTRL_FREEZE;
        end
        ERR:     w_ctrl = CTRL_FREEZE;
        default: w_ctrl = CTRL_IDLE;
      endcase
    end
  end

  // Sequencer state, memory-wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_busy) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!bus.dmem_ready) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            if (r_wait_cnt == WAIT_LAST) begin
              r_state   <= ERR;
              r_mem_err <= 1'b1;
            end
          end else begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end
        end
        ERR:     r_mem_err <= 1'b1;
        default: r_state   <= RUN;
      endcase
    end
  end

  // Saturating count of cycles the PC was held, excluding the dead ERR state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (!w_ctrl.pc_en && (r_state != ERR) && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign bus.dmem_req      = w_dmem_req;
  assign bus.pc_en         = w_ctrl.pc_en;
  assign bus.if_id_en      = w_ctrl.if_id_en;
  assign bus.if_id_flush   = w_ctrl.if_id_flush;
  assign bus.id_ex_en      = w_ctrl.id_ex_en;
  assign bus.id_ex_flush   = w_ctrl.id_ex_flush;
  assign bus.ex_mem_en     = w_ctrl.ex_mem_en;
  assign bus.mem_wb_bubble = w_ctrl.mem_wb_bubble;
  assign bus.mem_err       = r_mem_err;
  assign bus.stall_cycles  = r_stall_cycles;
  assign bus.state_dbg     = r_state;
endmodule
